// File: rtl/neuron_mac_ctrl.sv
// neuron_mac_ctrl
//
// This block sequences one dot product of NUM_INPUTS input/weight pairs
// through an external single-neuron multiplier.
//
// - After a start pulse, the block reads pairs 0..NUM_INPUTS-1, one pair per
//   cycle, over an asynchronous-read port (rd_idx -> in_data/wt_data).
// - It forwards each pair to the multiplier (nrn_in/nrn_wt).
// - It accumulates the returned product (nrn_out) into a widened accumulator,
//   so intermediate sums cannot overflow.
// - It pulses done for one cycle and presents result/ovf together.
//
// Build option:
//   NEURON_MAC_SATURATE_EN  - when defined, an out-of-range sum clamps result
//                             to 65535 / -65536. When undefined, result keeps
//                             the low 17 bits of the sum (two's-complement
//                             wrap).
//   ovf is identical in both builds.

module neuron_mac_ctrl #(
  parameter int NUM_INPUTS = 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  output logic [$clog2(NUM_INPUTS)-1:0] rd_idx,
  input  logic signed [13:0]            in_data,
  input  logic signed [4:0]             wt_data,
  output logic signed [13:0]            nrn_in,
  output logic signed [4:0]             nrn_wt,
  input  logic signed [16:0]            nrn_out,
  output logic signed [16:0]            result,
  output logic                          busy,
  output logic                          done,
  output logic                          ovf
);

  localparam int IDX_W = $clog2(NUM_INPUTS);
  // Headroom of log2(NUM_INPUTS) bits: NUM_INPUTS full-scale 17-bit products
  // always fit, so overflow is judged on the exact sum.
  localparam int ACC_W = 17 + IDX_W;

  localparam logic signed [ACC_W-1:0] SUM_MAX  = ACC_W'(65535);
  localparam logic signed [ACC_W-1:0] SUM_MIN  = -ACC_W'(65536);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        rd_idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [16:0]      result_q;
  logic                    ovf_q;
  logic                    busy_q;
  logic                    done_q;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_d;
  logic signed [16:0]      result_d;
  logic                    ovf_d;
  logic                    last_pair;

  // Operand routing: the multiplier sees live read data only while
  // accumulating. In every other state it sees zeros.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    nrn_in = '0;
    nrn_wt = '0;
    if (busy_q) begin
      nrn_in = in_data;
      nrn_wt = wt_data;
    end
  end

  // Running sum including this cycle's product, plus the range check and
  // the final-result formatting that are latched on entry to DONE.
  always_comb begin
    prod_ext  = {{IDX_W{nrn_out[16]}}, nrn_out};
    sum_d     = acc_q + prod_ext;
    ovf_d     = (sum_d > SUM_MAX) || (sum_d < SUM_MIN);
    last_pair = (rd_idx_q == LAST_IDX);
`ifdef NEURON_MAC_SATURATE_EN
    if (ovf_d) begin
      result_d = sum_d[ACC_W-1] ? -17'sd65536 : 17'sd65535;
    end else begin
      result_d = sum_d[16:0];
    end
`else
    result_d = sum_d[16:0];
`endif
  end

  // Control FSM. All status outputs are registered alongside the state, so
  // busy/done/result/ovf change only on clock edges (or on reset).
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: this block has no memories, only control and datapath registers.
    // Every one of them is cleared by the async reset, so an aborted run
    // leaves no trace.
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      rd_idx_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      done_q <= 1'b0;
      unique case (state_q)
        // IDLE and DONE both accept a new start. Accepting it in DONE gives
        // back-to-back runs with no idle gap.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q  <= ST_ACCUM;
            busy_q   <= 1'b1;
            acc_q    <= '0;
            rd_idx_q <= '0;
          end else begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
          end
        end
        // start is deliberately not looked at here: a run cannot be
        // restarted or extended once it is in flight.
        ST_ACCUM: begin
          acc_q    <= sum_d;
          rd_idx_q <= rd_idx_q + IDX_W'(1);
          if (last_pair) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= result_d;
            ovf_q    <= ovf_d;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          rd_idx_q <= '0;
        end
      endcase
    end
  end

  assign rd_idx = rd_idx_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Self-checking bench for neuron_mac_ctrl (NUM_INPUTS = 8).
// Expected values in the directed tables are hand-derived constants. The
// random runs use an arithmetic dot-product model over the bench's arrays.
// Define NEURON_MAC_SATURATE_EN for both bench and RTL to check the
// saturating build.

module tb_neuron_mac_ctrl;

  localparam int N     = 8;
  localparam int IDX_W = $clog2(N);

  logic                     clk;
  logic                     n_rst;
  logic                     start;
  logic [IDX_W-1:0]         rd_idx;
  logic signed [13:0]       in_data;
  logic signed [4:0]        wt_data;
  logic signed [13:0]       nrn_in;
  logic signed [4:0]        nrn_wt;
  logic signed [16:0]       nrn_out;
  logic signed [16:0]       result;
  logic                     busy;
  logic                     done;
  logic                     ovf;

  logic signed [13:0] in_mem [N];
  logic signed [4:0]  wt_mem [N];
  logic signed [31:0] prod;

  int n_vec = 0;
  int n_err = 0;

  neuron_mac_ctrl #(.NUM_INPUTS(N)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .rd_idx  (rd_idx),
    .in_data (in_data),
    .wt_data (wt_data),
    .nrn_in  (nrn_in),
    .nrn_wt  (nrn_wt),
    .nrn_out (nrn_out),
    .result  (result),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  // Asynchronous-read sample/weight store and combinational multiplier.
  assign in_data = in_mem[rd_idx];
  assign wt_data = wt_mem[rd_idx];
  assign prod    = 32'(nrn_in) * 32'(nrn_wt);
  assign nrn_out = prod[16:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    in_a;
    int    wt_a;   // even indices
    int    in_b;
    int    wt_b;   // odd indices
    int    exp_result;
    int    exp_ovf;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_alt(input int in_a, input int wt_a, input int in_b, input int wt_b);
    for (int i = 0; i < N; i++) begin
      in_mem[i] = (i % 2 == 0) ? 14'(in_a) : 14'(in_b);
      wt_mem[i] = (i % 2 == 0) ? 5'(wt_a) : 5'(wt_b);
    end
  endtask

  // Reference: exact dot product, then range check and 17-bit formatting.
  task automatic model(output int r, output int o);
    longint s;
    logic signed [63:0] s64;
    logic signed [16:0] low;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(in_mem[i]) * longint'(wt_mem[i]);
    o = (s > 65535 || s < -65536) ? 1 : 0;
    s64 = s;
    low = s64[16:0];
`ifdef NEURON_MAC_SATURATE_EN
    r = (o == 0) ? int'(s) : ((s > 0) ? 65535 : -65536);
`else
    r = int'(low);
`endif
  endtask

  // One full run: start pulse, then track busy/done until done or timeout.
  task automatic run_vec(input string name, input int exp_r, input int exp_o);
    int busy_cnt;
    int done_cyc;
    int r_at_done;
    int o_at_done;
    busy_cnt  = 0;
    done_cyc  = -1;
    r_at_done = 0;
    o_at_done = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 4 * N; c++) begin
      if (c > 1) @(negedge clk);
      if (busy) busy_cnt++;
      if (busy) check({name, " nrn_in"}, nrn_in, in_mem[rd_idx]);
      if (done) begin
        done_cyc  = c;
        r_at_done = int'(result);
        o_at_done = int'(ovf);
        break;
      end
    end
    check({name, " done cycle"}, done_cyc, N + 1);
    check({name, " busy cycles"}, busy_cnt, N);
    check({name, " result"}, r_at_done, exp_r);
    check({name, " ovf"}, o_at_done, exp_o);
    @(negedge clk);
    check({name, " done width"}, done, 0);
    check({name, " result hold"}, int'(result), exp_r);
  endtask

  vec_t vecs[$];

  initial begin
    int dcount;
    int first_done;
    int second_done;
    int cyc;
    int er;
    int eo;
    bit seen;

    // Directed table: {name, even pair, odd pair, result, ovf}.
    vecs.push_back('{"all3000x1",   3000, 1,  3000, 1,  24000, 0});
`ifdef NEURON_MAC_SATURATE_EN
    vecs.push_back('{"all3000x15",  3000, 15, 3000, 15, 65535, 1});
    vecs.push_back('{"negovf",     -4095, 15, -4095, 15, -65536, 1});
    vecs.push_back('{"pos65536",    4096, 4,  0,    0,  65535, 1});
    vecs.push_back('{"neg65540",   -4096, 4,  -1,   1,  -65536, 1});
`else
    vecs.push_back('{"all3000x15",  3000, 15, 3000, 15, -33216, 1});
    vecs.push_back('{"negovf",     -4095, 15, -4095, 15, 32888, 1});
    vecs.push_back('{"pos65536",    4096, 4,  0,    0,  -65536, 1});
    vecs.push_back('{"neg65540",   -4096, 4,  -1,   1,  65532, 1});
`endif
    vecs.push_back('{"alternating", -3000, -1, -1,  -15, 12060, 0});
    vecs.push_back('{"zero_wt",     1234, 0,  -777, 0,  0,     0});
    vecs.push_back('{"neg65536",   -4096, 4,  0,    0,  -65536, 0});
    vecs.push_back('{"pos65520",    4095, 4,  0,    0,  65520, 0});

    start = 1'b0;
    n_rst = 1'b0;
    load_alt(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset ovf", ovf, 0);
    check("reset result", int'(result), 0);
    check("reset rd_idx", rd_idx, 0);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle nrn_in", nrn_in, 0);
    check("idle nrn_wt", nrn_wt, 0);

    foreach (vecs[i]) begin
      load_alt(vecs[i].in_a, vecs[i].wt_a, vecs[i].in_b, vecs[i].wt_b);
      run_vec(vecs[i].name, vecs[i].exp_result, vecs[i].exp_ovf);
    end

    // Random data against the arithmetic model.
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) begin
        in_mem[i] = 14'($signed($urandom_range(8190)) - 4095);
        wt_mem[i] = 5'($signed($urandom_range(31)) - 16);
      end
      model(er, eo);
      run_vec($sformatf("rand%0d", k), er, eo);
    end

    // start re-pulsed mid-run must not restart or add a done.
    load_alt(3000, 1, 3000, 1);
    dcount = 0;
    first_done = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 3 * N; c++) begin
      if (c > 1) @(negedge clk);
      start = (c == 3 || c == 5) ? 1'b1 : 1'b0;
      if (done) begin
        dcount++;
        if (first_done < 0) first_done = c;
      end
    end
    start = 1'b0;
    check("repulse done count", dcount, 1);
    check("repulse done cycle", first_done, N + 1);
    check("repulse result", int'(result), 24000);

    // start during DONE: next run begins immediately.
    repeat (2) @(negedge clk);
    load_alt(-3000, -1, -1, -15);
    first_done = -1;
    second_done = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (cyc <= 3 * N && !seen) begin
      if (done) begin
        first_done = cyc;
        start = 1'b1;
        seen = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    @(negedge clk); cyc++;
    start = 1'b0;
    check("b2b busy after done", busy, 1);
    check("b2b no double done", done, 0);
    while (cyc <= 6 * N && second_done < 0) begin
      if (done) second_done = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("b2b first done", first_done, N + 1);
    check("b2b done spacing", second_done - first_done, N + 1);
    check("b2b result", int'(result), 12060);

    // Reset mid-run at rd_idx=3, after a run left result/ovf nonzero.
    load_alt(3000, 15, 3000, 15);
`ifdef NEURON_MAC_SATURATE_EN
    run_vec("pre_reset", 65535, 1);
`else
    run_vec("pre_reset", -33216, 1);
`endif
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4 * N && !seen; c++) begin
      if (busy && rd_idx == 3) seen = 1'b1;
      else @(negedge clk);
    end
    check("reached rd_idx 3", seen, 1);
    n_rst = 1'b0;
    start = 1'b1;
    #1;
    check("midrun reset busy", busy, 0);
    check("midrun reset done", done, 0);
    check("midrun reset ovf", ovf, 0);
    check("midrun reset result", int'(result), 0);
    check("midrun reset rd_idx", rd_idx, 0);
    @(negedge clk);
    check("start ignored in reset", busy, 0);
    start = 1'b0;
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("no resume after reset", busy, 0);
    load_alt(3000, 1, 3000, 1);
    run_vec("post_reset", 24000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
